// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle sequencer.
// State encodings and PC source select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [1:0] PCP4  = 2'd0;
    localparam logic [1:0] BR    = 2'd1;
    localparam logic [1:0] JMP   = 2'd2;
    localparam logic [1:0] ENTRY = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: counts stalled cycles of one access.
// Ports: clk, rst, clr (restart), en (stalled cycle), timeout.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    // Fires on the TIMEOUT-th consecutive stalled cycle.
    assign timeout = en && (count == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && !timeout)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP/ERROR.
// Ports: decode flags, mem_ready, int_req in; strobes, state, counters out.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             isStype,
    input  logic             isRtype,
    input  logic             isItype,
    input  logic             isLw,
    input  logic             isjump,
    input  logic             isbranch,
    input  logic             mem_ready,
    input  logic             int_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             int_ack,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    state_t st, nxt;
    logic   retire;
    logic   waiting;
    logic   tmo;

    assign state   = st;
    assign waiting = (st == ST_FETCH || st == ST_MEM) && !mem_ready;

    // Any non-stalled cycle restarts the count, so each
    // FETCH/MEM entry begins from zero.
    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!waiting),
        .en      (waiting),
        .timeout (tmo)
    );

    always_comb begin
        nxt          = st;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PCP4;
        rf_we        = 1'b0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        int_ack      = 1'b0;
        retire       = 1'b0;
        unique case (st)
            ST_FETCH: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    nxt   = ST_DECODE;
                end else if (tmo) begin
                    nxt = ST_ERROR;
                end
            end
            ST_DECODE: nxt = int_req ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                if (isjump) begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = JMP;
                    retire = 1'b1;
                    nxt    = ST_FETCH;
                end else if (isbranch) begin
                    pc_we  = 1'b1;
                    pc_src = BR;
                    retire = 1'b1;
                    nxt    = ST_FETCH;
                end else if (isLw || isStype) begin
                    nxt = ST_MEM;
                end else if (isRtype || isItype) begin
                    nxt = ST_WB;
                end else begin
                    nxt = ST_ERROR;
                end
            end
            ST_MEM: begin
                mem_addr_sel = 1'b1;
                mem_re       = isLw;
                // Load outranks store if both flags are set.
                mem_we       = isStype && !isLw;
                if (mem_ready) begin
                    if (isLw) begin
                        nxt = ST_WB;
                    end else begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        nxt    = ST_FETCH;
                    end
                end else if (tmo) begin
                    nxt = ST_ERROR;
                end
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                nxt    = ST_FETCH;
            end
            ST_TRAP: begin
                pc_we   = 1'b1;
                pc_src  = ENTRY;
                int_ack = 1'b1;
                nxt     = ST_FETCH;
            end
            ST_ERROR: nxt = ST_ERROR;
            default:  nxt = ST_ERROR;
        endcase
        if (rst) begin
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = PCP4;
            rf_we        = 1'b0;
            mem_re       = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            int_ack      = 1'b0;
            retire       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ST_FETCH;
            err     <= 1'b0;
            instret <= '0;
            cycles  <= '0;
        end else begin
            st     <= nxt;
            err    <= err || (nxt == ST_ERROR);
            cycles <= cycles + 1'b1;
            if (retire)
                instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl, TIMEOUT=4.
// Per-cycle vector table plus a counter sequence.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        isStype, isRtype, isItype, isLw, isjump, isbranch;
    logic        mem_ready, int_req;
    logic        ir_we, pc_we, rf_we, mem_re, mem_we, mem_addr_sel;
    logic        int_ack, err;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [31:0] instret, cycles;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .isStype(isStype), .isRtype(isRtype), .isItype(isItype),
        .isLw(isLw), .isjump(isjump), .isbranch(isbranch),
        .mem_ready(mem_ready), .int_req(int_req),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .rf_we(rf_we), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .int_ack(int_ack),
        .err(err), .state(state),
        .instret(instret), .cycles(cycles)
    );

    // flags: {isStype,isRtype,isItype,isLw,isjump,isbranch}
    localparam logic [5:0] F0 = 6'b000000;
    localparam logic [5:0] FS = 6'b100000;
    localparam logic [5:0] FR = 6'b010000;
    localparam logic [5:0] FL = 6'b000100;
    localparam logic [5:0] FJ = 6'b000010;
    localparam logic [5:0] FB = 6'b000001;

    // {ir_we,pc_we,pc_src[1:0],rf_we,mem_re,mem_we,sel,int_ack,err}
    localparam logic [9:0] E0   = 10'b0000000000;
    localparam logic [9:0] EFW  = 10'b0000010000;
    localparam logic [9:0] EFR  = 10'b1000010000;
    localparam logic [9:0] EWB  = 10'b0100100000;
    localparam logic [9:0] EML  = 10'b0000010100;
    localparam logic [9:0] EMS  = 10'b0100001100;
    localparam logic [9:0] EBR  = 10'b0101000000;
    localparam logic [9:0] EJM  = 10'b0110100000;
    localparam logic [9:0] ETR  = 10'b0111000010;
    localparam logic [9:0] EER  = 10'b0000000001;

    typedef struct {
        logic       r;
        logic [5:0] f;
        logic       rdy;
        logic       irq;
        logic [2:0] st;
        logic [9:0] eo;
        logic [7:0] ni;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [5:0] f,
                       input logic rdy, input logic irq,
                       input logic [2:0] s, input logic [9:0] e,
                       input logic [7:0] ni);
        vec_t v;
        v.r = r; v.f = f; v.rdy = rdy; v.irq = irq;
        v.st = s; v.eo = e; v.ni = ni;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [5:0] f,
                         input logic rdy, input logic irq);
        rst = r;
        {isStype, isRtype, isItype, isLw, isjump, isbranch} = f;
        mem_ready = rdy;
        int_req   = irq;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    logic [9:0] outs;
    assign outs = {ir_we, pc_we, pc_src, rf_we, mem_re, mem_we,
                   mem_addr_sel, int_ack, err};

    initial begin
        // R-type, zero wait
        add(0, FR, 1, 0, 3'd0, EFR, 0);
        add(0, FR, 1, 0, 3'd1, E0,  0);
        add(0, FR, 1, 0, 3'd2, E0,  0);
        add(0, FR, 1, 0, 3'd4, EWB, 0);
        // load: FETCH 2 waits, MEM 1 wait
        add(0, FL, 0, 0, 3'd0, EFW, 1);
        add(0, FL, 0, 0, 3'd0, EFW, 1);
        add(0, FL, 1, 0, 3'd0, EFR, 1);
        add(0, FL, 1, 0, 3'd1, E0,  1);
        add(0, FL, 1, 0, 3'd2, E0,  1);
        add(0, FL, 0, 0, 3'd3, EML, 1);
        add(0, FL, 1, 0, 3'd3, EML, 1);
        add(0, FL, 1, 0, 3'd4, EWB, 1);
        // store
        add(0, FS, 1, 0, 3'd0, EFR, 2);
        add(0, FS, 1, 0, 3'd1, E0,  2);
        add(0, FS, 1, 0, 3'd2, E0,  2);
        add(0, FS, 1, 0, 3'd3, EMS, 2);
        // branch
        add(0, FB, 1, 0, 3'd0, EFR, 3);
        add(0, FB, 1, 0, 3'd1, E0,  3);
        add(0, FB, 1, 0, 3'd2, EBR, 3);
        // jump
        add(0, FJ, 1, 0, 3'd0, EFR, 4);
        add(0, FJ, 1, 0, 3'd1, E0,  4);
        add(0, FJ, 1, 0, 3'd2, EJM, 4);
        // interrupt raised in FETCH
        add(0, FR, 1, 1, 3'd0, EFR, 5);
        add(0, FR, 1, 1, 3'd1, E0,  5);
        add(0, FR, 1, 1, 3'd5, ETR, 5);
        add(0, FR, 1, 0, 3'd0, EFR, 5);
        add(0, FR, 1, 0, 3'd1, E0,  5);
        add(0, FR, 1, 0, 3'd2, E0,  5);
        add(0, FR, 1, 0, 3'd4, EWB, 5);
        // fetch timeout
        add(0, FR, 0, 0, 3'd0, EFW, 6);
        add(0, FR, 0, 0, 3'd0, EFW, 6);
        add(0, FR, 0, 0, 3'd0, EFW, 6);
        add(0, FR, 0, 0, 3'd0, EFW, 6);
        add(0, FR, 0, 0, 3'd7, EER, 6);
        add(0, FR, 1, 0, 3'd7, EER, 6);
        add(1, FR, 1, 0, 3'd7, EER, 6);
        // reset during MEM of a store
        add(0, FS, 1, 0, 3'd0, EFR, 0);
        add(0, FS, 1, 0, 3'd1, E0,  0);
        add(0, FS, 1, 0, 3'd2, E0,  0);
        add(1, FS, 0, 0, 3'd3, E0,  0);
        // no flags in EXEC
        add(0, F0, 1, 0, 3'd0, EFR, 0);
        add(0, F0, 1, 0, 3'd1, E0,  0);
        add(0, F0, 1, 0, 3'd2, E0,  0);
        add(0, F0, 1, 0, 3'd7, EER, 0);
        // ready on the timeout cycle wins
        add(1, FR, 0, 0, 3'd7, EER, 0);
        add(0, FR, 0, 0, 3'd0, EFW, 0);
        add(0, FR, 0, 0, 3'd0, EFW, 0);
        add(0, FR, 0, 0, 3'd0, EFW, 0);
        add(0, FR, 1, 0, 3'd0, EFR, 0);
        add(0, FR, 1, 0, 3'd1, E0,  0);

        drive(1, F0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_cycles", cycles, 32'd0);
        chk("reset_strobes", 32'(outs), 32'd0);

        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].f, vq[i].rdy, vq[i].irq);
            @(negedge clk);
            n_cmp++;
            if (state !== vq[i].st) begin
                n_bad++;
                $display("FAIL row%0d state: got %0d want %0d",
                         i, state, vq[i].st);
            end
            n_cmp++;
            if (outs !== vq[i].eo) begin
                n_bad++;
                $display("FAIL row%0d outs: got %b want %b",
                         i, outs, vq[i].eo);
            end
            n_cmp++;
            if (instret[7:0] !== vq[i].ni) begin
                n_bad++;
                $display("FAIL row%0d instret: got %0d want %0d",
                         i, instret, vq[i].ni);
            end
            @(posedge clk);
            #1;
        end

        // counters: reset then 10 free-running R-type cycles
        drive(1, FR, 1, 0);
        @(posedge clk);
        #1;
        drive(0, FR, 1, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("cycles_10", cycles, 32'd10);
        chk("instret_10", instret, 32'd2);
        chk("state_10", 32'(state), 32'd2);
        chk("err_10", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RISC-V datapath (IF/ID/EX/DM/WB/PC stages, shared single-port `mem`).
- Replaces single-cycle implicit sequencing with an FSM: FETCH, DECODE, EXEC, MEM, WB, TRAP, ERROR.
- Instruction fetch and data access share one memory port through `mem_addr_sel`.
- Consumes yC1 decode flags; drives register/memory/PC write strobes, interrupt handshake and retirement/cycle counters.

Parameters:
- TIMEOUT, 16, max cycles to wait for `mem_ready` in FETCH/MEM before entering ERROR; minimum 1.
- CNT_W, 32, width of `instret` and `cycles` counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- isStype, isRtype, isItype, isLw, isjump, isbranch  in  1 each  decode flags for the instruction in IR
- mem_ready  in  1  memory completes the current access this cycle
- int_req  in  1  interrupt request; level, held until `int_ack`
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- pc_src  out  2  0 = PCp4, 1 = branch (datapath applies `zero`), 2 = jump target, 3 = entryPoint
- rf_we  out  1  register-file write
- mem_re, mem_we  out  1 each  memory read/write request
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- int_ack  out  1  one-cycle interrupt acknowledge
- err  out  1  sticky error flag
- state  out  3  current state, for debug
- instret  out  CNT_W  retired instruction count
- cycles  out  CNT_W  cycles since reset

Behaviour:
- Reset: while `rst`=1 at the edge, state←FETCH, `err`←0, counters←0, wait timer←0. All strobes are forced to 0 while `rst` is high. Reset mid-access abandons the access. No write strobe is asserted in a cycle where `rst`=1.
- Strobes are combinational from state, `mem_ready` and flags (Moore plus ready). `state`, `err` and counters are registered.
- FETCH: `mem_re`=1, `mem_addr_sel`=0. When `mem_ready`=1: `ir_we`=1, next state DECODE.
- DECODE: one cycle, no strobes. `int_req`=1 → TRAP; otherwise → EXEC.
- EXEC: one cycle. Flag priority is isjump > isbranch > isLw > isStype > (isRtype|isItype).
  - jump: `rf_we`=1, `pc_we`=1, `pc_src`=2, retire, → FETCH.
  - branch: `pc_we`=1, `pc_src`=1, retire, → FETCH.
  - load/store: → MEM.
  - R/I type: → WB.
  - No flag set: → ERROR.
- MEM: `mem_addr_sel`=1; `mem_re`=isLw, `mem_we`=isStype.
  - Store, on `mem_ready`: `pc_we`=1, `pc_src`=0, retire, → FETCH.
  - Load, on `mem_ready`: → WB.
- WB: `rf_we`=1, `pc_we`=1, `pc_src`=0, retire, → FETCH.
- TRAP: `pc_we`=1, `pc_src`=3, `int_ack`=1, → FETCH. The instruction in IR is discarded (not retired).
- ERROR: absorbing until reset. `err`=1 and all strobes 0.
- Wait timer:
  - Clears on every entry to FETCH or MEM.
  - Increments each cycle spent in FETCH/MEM with `mem_ready`=0.
  - Count reaching TIMEOUT with `mem_ready` still 0 → ERROR on the next edge.
  - `mem_ready` in the same cycle as the timeout condition wins (access completes).
- `int_req` is sampled only in DECODE. A request asserted during FETCH/EXEC/MEM/WB waits for the next DECODE.
- Latency with zero-wait memory (cycles from FETCH entry to next FETCH): branch/jump 3, R/I 4, store 4, load 5, trap 3.
- `instret` increments by 1 on each retire cycle; `cycles` increments every non-reset cycle. Both wrap modulo 2^CNT_W.

Decomposition:
- Shared package `mc_ctrl_pkg`:
  - state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, ERROR=7
  - PC_SRC constants: PCP4, BR, JMP, ENTRY
- Sub-module `mem_wait_timer`: clear/enable/timeout counter, parameter TIMEOUT.

Test Plan:
- R-type, `mem_ready` tied 1: states 0,1,2,4 → `rf_we` and `pc_we` in cycle 3 only; `instret`=1 after 4 cycles.
- Load with FETCH ready after 2 wait cycles and MEM after 1: total 8 cycles. `mem_re`=1 in FETCH and MEM, `mem_addr_sel`=1 in MEM, `rf_we` in WB.
- Store: `mem_we`=1 only in MEM ready cycle with `pc_src`=0. Branch: `pc_src`=1, `pc_we`=1 in EXEC, no `rf_we`.
- `int_req`=1 raised during FETCH: DECODE→TRAP, `int_ack` for one cycle, `pc_src`=3, `instret` unchanged.
- `mem_ready` held 0 with TIMEOUT=4: ERROR after 4 waiting cycles, `err`=1 sticky. `rst` pulse → FETCH, `err`=0, counters 0.
- `rst` asserted during MEM of a store: `mem_we` never asserted. All flags 0 in EXEC → ERROR.
